// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one sequential signed multiplier engine among N_REQ lanes.
// One operation in flight: IDLE -> ISSUE -> WAIT -> RESP, with a watchdog on the engine.
module mult_share_sched #(
  parameter  int N_REQ     = 4,
  parameter  int BIT_WIDTH = 8,
  parameter  int TIMEOUT   = 32,
  localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_a,
  input  logic [N_REQ*BIT_WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]             rsp_valid,
  input  logic [N_REQ-1:0]             rsp_ready,
  output logic [2*BIT_WIDTH-1:0]       rsp_data,
  output logic                         rsp_err,
  output logic                         mul_start,
  output logic [BIT_WIDTH-1:0]         mul_a,
  output logic [BIT_WIDTH-1:0]         mul_b,
  input  logic                         mul_done,
  input  logic [2*BIT_WIDTH-1:0]       mul_result,
  output logic                         busy,
  output logic [GW-1:0]                grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [GW-1:0]           r_last_grant;
  logic [GW-1:0]           r_grant_id;
  logic [CW-1:0]           r_cnt;
  logic [BIT_WIDTH-1:0]    r_mul_a;
  logic [BIT_WIDTH-1:0]    r_mul_b;
  logic                    r_mul_start;
  logic                    r_busy;
  logic                    r_rsp_active;
  logic [2*BIT_WIDTH-1:0]  r_rsp_data;
  logic                    r_rsp_err;

  logic                    w_found;
  logic [GW-1:0]           w_winner;
  logic [BIT_WIDTH-1:0]    w_sel_a;
  logic [BIT_WIDTH-1:0]    w_sel_b;
  logic                    w_idle;

  // Rotating priority search starting just after the last lane served.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(r_last_grant) + k) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = GW'(idx);
      end
    end
  end

  assign w_idle  = (r_state == S_IDLE);
  assign w_sel_a = req_a[int'(w_winner)*BIT_WIDTH +: BIT_WIDTH];
  assign w_sel_b = req_b[int'(w_winner)*BIT_WIDTH +: BIT_WIDTH];

  // rst_n gates req_ready so every output reads 0 while reset is held.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign req_ready[gi] = rst_n && w_idle && w_found && (w_winner == GW'(gi));
      assign rsp_valid[gi] = r_rsp_active && (r_grant_id == GW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= GW'(N_REQ - 1);
      r_grant_id   <= '0;
      r_cnt        <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_active <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_mul_a     <= w_sel_a;
            r_mul_b     <= w_sel_b;
            r_grant_id  <= w_winner;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the watchdog's final cycle still counts as success.
          if (mul_done) begin
            r_rsp_data   <= mul_result;
            r_rsp_err    <= 1'b0;
            r_rsp_active <= 1'b1;
            r_state      <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_active <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[r_grant_id]) begin
            r_rsp_active <= 1'b0;
            r_last_grant <= r_grant_id;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched: vector table, corner sequences and a
// randomized round-robin run against a transaction-level reference model.
module tb_mult_share_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a = '0;
  logic [N*W-1:0]    req_b = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '0;
  logic [2*W-1:0]    rsp_data;
  logic              rsp_err;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done = 1'b0;
  logic [2*W-1:0]    mul_result = '0;
  logic              busy;
  logic [1:0]        grant_id;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          eng_delay = 1;
  int          eng_left  = 0;
  logic        eng_ovr   = 1'b0;
  logic [15:0] eng_val   = '0;
  logic        extra_done = 1'b0;

  mult_share_sched #(.N_REQ(N), .BIT_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Engine model: eng_delay=d raises done on the d-th WAIT cycle; 0 never completes.
  always @(negedge clk) begin
    mul_done = extra_done;
    if (extra_done) mul_result = 16'h1234;
    if (!rst_n) eng_left = 0;
    else if (mul_start) eng_left = eng_delay;
    else if (eng_left > 0) begin
      eng_left = eng_left - 1;
      if (eng_left == 0) begin
        mul_done   = 1'b1;
        mul_result = eng_ovr ? eng_val : prod(mul_a, mul_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid == '0 && cyc < TO + 10) begin
      step();
      cyc++;
    end
  endtask

  task automatic finish_op();
    int c;
    wait_rsp(c);
    chk("finish_rsp_seen", (rsp_valid != '0), 1);
    rsp_ready = '1;
    step();
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; extra_done = 1'b0;
    step(); step();
    chk("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy, grant_id}, 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_op(input int lane, input logic [7:0] a, input logic [7:0] b, input int delay,
                        input logic [15:0] exp_data, input logic exp_err);
    int   lat;
    logic unstable;
    eng_delay = delay; eng_ovr = 1'b0;
    req_a[lane*W +: W] = a;
    req_b[lane*W +: W] = b;
    req_valid = N'(1 << lane);
    rsp_ready = '0;
    #1;
    chk("op_req_ready", req_ready, 1 << lane);
    step();
    req_valid = '0;
    chk("op_mul_start", mul_start, 1);
    chk("op_grant_id", grant_id, lane);
    chk("op_mul_a", mul_a, a);
    chk("op_mul_b", mul_b, b);
    chk("op_busy", busy, 1);
    lat = 1;
    unstable = 1'b0;
    while (rsp_valid == '0 && lat < TO + 10) begin
      step();
      lat++;
      if (mul_a !== a || mul_b !== b) unstable = 1'b1;
    end
    chk("op_latency", lat, (delay == 0) ? TO + 2 : delay + 2);
    chk("op_rsp_valid", rsp_valid, 1 << lane);
    chk("op_rsp_data", rsp_data, exp_data);
    chk("op_rsp_err", rsp_err, exp_err);
    chk("op_operands_stable", unstable, 0);
    $display("[TB] op lane=%0d a=%02h b=%02h data=%04h err=%0d latency=%0d", lane, a, b, rsp_data, rsp_err, lat);
    rsp_ready = '1;
    step();
    rsp_ready = '0;
    chk("op_busy_after", busy, 0);
    chk("op_rsp_valid_after", rsp_valid, 0);
  endtask

  typedef struct {
    int          lane;
    logic [7:0]  a;
    logic [7:0]  b;
    int          delay;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int          c;
    int          grants[$];
    int          exp_g[6];
    logic        bad;
    logic [15:0] held;
    logic [N-1:0] pend;
    logic [7:0]  pa[N];
    logic [7:0]  pb[N];
    int          m_last;
    int          exp_w;

    vt[0] = '{1, 8'h03, 8'h05, 1,  16'h000F, 1'b0};
    vt[1] = '{2, 8'hFF, 8'h0F, 3,  16'hFFF1, 1'b0};
    vt[2] = '{0, 8'h7F, 8'h7F, 2,  16'h3F01, 1'b0};
    vt[3] = '{3, 8'h80, 8'h80, 5,  16'h4000, 1'b0};
    vt[4] = '{0, 8'h80, 8'h7F, 4,  16'hC080, 1'b0};
    vt[5] = '{0, 8'h12, 8'h34, 0,  16'h0000, 1'b1};
    vt[6] = '{1, 8'hFE, 8'h05, 32, 16'hFFF6, 1'b0};
    exp_g = '{0, 1, 2, 3, 0, 1};

    do_reset();
    for (int i = 0; i < 7; i++)
      run_op(vt[i].lane, vt[i].a, vt[i].b, vt[i].delay, vt[i].data, vt[i].err);

    // Spurious done during ISSUE, real done two cycles later.
    eng_delay = 2; eng_ovr = 1'b1; eng_val = 16'hFFF1;
    req_a[3*W +: W] = 8'h01; req_b[3*W +: W] = 8'h02;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    extra_done = 1'b1;
    step();
    extra_done = 1'b0;
    wait_rsp(c);
    chk("spurious_lane", rsp_valid, 4'b1000);
    chk("spurious_data", rsp_data, 16'hFFF1);
    chk("spurious_err", rsp_err, 0);
    $display("[TB] spurious done: data=%04h", rsp_data);
    rsp_ready = '1; step(); rsp_ready = '0;
    eng_ovr = 1'b0;

    // Fairness with every lane requesting continuously.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 8'(i + 1);
      req_b[i*W +: W] = 8'h03;
    end
    eng_delay = 3; rsp_ready = '1; req_valid = '1;
    c = 0;
    while (grants.size() < 6 && c < 100) begin
      step();
      c++;
      if (mul_start) grants.push_back(int'(grant_id));
    end
    req_valid = '0;
    chk("fair_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("fair_order", (i < grants.size()) ? grants[i] : -1, exp_g[i]);
      $display("[TB] fairness grant %0d -> lane %0d", i, (i < grants.size()) ? grants[i] : -1);
    end
    c = 0;
    while (busy && c < 20) begin step(); c++; end
    rsp_ready = '0;

    // Backpressure on lane 2 while lane 0 waits.
    eng_delay = 1;
    req_a[2*W +: W] = 8'h05; req_b[2*W +: W] = 8'h06;
    req_a[0 +: W] = 8'h02;   req_b[0 +: W] = 8'h02;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0001;
    wait_rsp(c);
    held = rsp_data;
    chk("bp_data", held, 16'h001E);
    bad = 1'b0;
    rsp_ready = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rsp_valid !== 4'b0100 || rsp_data !== held || req_ready !== 4'b0000 || mul_start) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    $display("[TB] backpressure lane 2 held 10 cycles data=%04h", rsp_data);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    chk("bp_next_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    chk("bp_next_grant", grant_id, 0);
    chk("bp_next_start", mul_start, 1);
    finish_op();

    // Reset in the middle of WAIT.
    eng_delay = 0;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step(); step(); step();
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_mid_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy, grant_id}, 0);
    step();
    rst_n = 1'b1;
    req_valid = '0;
    extra_done = 1'b1;
    step();
    extra_done = 1'b0;
    step(); step();
    chk("rst_late_done_rsp", rsp_valid, 0);
    chk("rst_late_done_busy", busy, 0);
    req_valid = 4'b0101;
    #1;
    chk("rst_lane0_first", req_ready, 4'b0001);
    $display("[TB] reset mid-wait: next ready=%b", req_ready);
    step();
    req_valid = '0;
    eng_delay = 1;
    finish_op();

    // Randomized multi-lane traffic against a round-robin reference.
    m_last = 0;
    pend = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || i == t % N)) begin
          pend[i] = 1'b1;
          pa[i] = 8'($urandom);
          pb[i] = 8'($urandom);
          req_a[i*W +: W] = pa[i];
          req_b[i*W +: W] = pb[i];
        end
      end
      req_valid = pend;
      #1;
      exp_w = -1;
      for (int k = 1; k <= N; k++)
        if (exp_w < 0 && pend[(m_last + k) % N]) exp_w = (m_last + k) % N;
      chk("rnd_ready", req_ready, 1 << exp_w);
      eng_delay = $urandom_range(1, 6);
      step();
      pend[exp_w] = 1'b0;
      req_valid = pend;
      wait_rsp(c);
      chk("rnd_lane", rsp_valid, 1 << exp_w);
      chk("rnd_data", rsp_data, prod(pa[exp_w], pb[exp_w]));
      chk("rnd_err", rsp_err, 0);
      $display("[TB] rnd %0d lane=%0d a=%02h b=%02h data=%04h", t, exp_w, pa[exp_w], pb[exp_w], rsp_data);
      bad = 1'b0;
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        rsp_ready = N'($urandom) & ~N'(1 << exp_w);
        step();
        if (rsp_valid !== N'(1 << exp_w)) bad = 1'b1;
      end
      chk("rnd_hold", bad, 0);
      rsp_ready = N'(1 << exp_w);
      step();
      rsp_ready = '0;
      m_last = exp_w;
    end
    req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
